fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC register and runs a valid/ready request and valid response handshake with instruction memory.
- Presents one instruction per accepted fetch to the IF/ID pipeline register.
- Upstream neighbour of the pipeline control block: it produces if_req and consumes pc_ctrl.
- Redirects on pc_ctrl.flush and discards any stale memory response in flight.

---
 rtl/fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC, issues at most one outstanding valid/ready request to
// instruction memory, presents each returned instruction to the IF/ID
// register and follows redirects from pipeline control. A response that
// belongs to a request issued before a flush is dropped.
//
// Ports:
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   pc_ctrl          {stall, flush} from pipeline control
//   redirect_pc      new PC, taken when pc_ctrl.flush=1
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address (the PC)
//   imem_resp_valid  one-cycle response strobe, in request order
//   imem_resp_data   fetched instruction
//   if_req           {stall_req, flush_req[4:0]} to pipeline control
//   if_valid         if_instr/if_pc carry a real instruction this cycle
//   if_instr         instruction to IF/ID (NOP_INSTR when if_valid=0)
//   if_pc            PC of if_instr
//
// Optional build macro RV5STAGE_FETCH_PERF_EN adds:
//   perf_fetched       instructions delivered (if_valid && !stall), saturating
//   perf_stall_cycles  cycles with if_req.stall_req=1, saturating
// -----------------------------------------------------------------------------

// Pipeline control handshake types shared with the control block.
typedef struct packed {
  logic stall;
  logic flush;
} PipeControl;

typedef struct packed {
  logic       stall_req;
  logic [4:0] flush_req;  // one bit per pipeline stage
} PipeRequest;

module fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  PipeControl      pc_ctrl,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output PipeRequest      if_req,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef RV5STAGE_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;

  // An instruction is available this cycle (before any flush kill). Built
  // from state and imem_resp_valid only, so stall_req never sees pc_ctrl and
  // the stall loop through pipeline control stays combinationally open.
  logic presenting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    if_instr       = NOP_INSTR;
    presenting     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end

      REQ: begin
        imem_req_valid = 1'b1;
        if (pc_ctrl.flush) begin
          pc_d = redirect_pc;
          // A request accepted alongside the flush is stale: drain it.
          state_d = imem_req_ready ? DRAIN : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_resp_valid) begin
          presenting = 1'b1;
          if (pc_ctrl.flush) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else begin
            if_valid = 1'b1;
            if_instr = imem_resp_data;
            hold_d   = imem_resp_data;
            if (!pc_ctrl.stall) begin
              pc_d    = pc_q + XLEN'(4);
              state_d = REQ;
            end else begin
              state_d = HOLD;
            end
          end
        end else if (pc_ctrl.flush) begin
          pc_d    = redirect_pc;
          state_d = DRAIN;
        end
      end

      HOLD: begin
        presenting = 1'b1;
        if (pc_ctrl.flush) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else begin
          if_valid = 1'b1;
          if_instr = hold_q;
          if (!pc_ctrl.stall) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = REQ;
          end
        end
      end

      DRAIN: begin
        if (pc_ctrl.flush) begin
          pc_d = redirect_pc;
        end
        if (imem_resp_valid) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_req_addr     = pc_q;
  assign if_pc             = pc_q;
  assign if_req.stall_req  = (state_q != BOOT) && !presenting;
  assign if_req.flush_req  = '0;

`ifdef RV5STAGE_FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (if_valid && !pc_ctrl.stall && (perf_fetched_q != 32'hFFFF_FFFF)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (if_req.stall_req && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// The reference model tracks the fetch stage as transactions: is a request
// outstanding, will its response be discarded, is an instruction being held,
// and what is the PC. A small memory model answers each accepted request
// after a configurable latency.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_ctrl = 2'b00;        // {stall, flush}
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [5:0]  if_req;                 // {stall_req, flush_req[4:0]}
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef RV5STAGE_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_ctrl         (pc_ctrl),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_req          (if_req),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
`ifdef RV5STAGE_FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;
  string cur_test = "none";

  // Transaction-level reference model
  bit          m_boot;
  bit          m_out;      // a request was accepted, response not yet seen
  bit          m_disc;     // that response must be thrown away
  bit          m_held;     // an instruction is held waiting for stall release
  logic [31:0] m_hdata;
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_stalls;

  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          lat = 1;
  bit          force_data = 1'b0;
  logic [31:0] forced_val = '0;

  logic [31:0] acc_q[$];   // addresses the bench saw accepted

  function automatic bit model_req();
    return !m_boot && !m_out && !m_held;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_out = 1'b0; m_disc = 1'b0; m_held = 1'b0;
    m_hdata = '0; m_pc = RESET_PC; m_fetched = '0; m_stalls = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_data = '0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance model.
  task automatic step(input bit stall, input bit flush, input logic [31:0] redir,
                      input bit ready);
    bit rv, req_v, pres, ev, esr, acc;
    logic [31:0] ei;
    logic [5:0]  ereq;
    @(negedge clk);
    rv = mem_busy && (mem_cnt == 0);
    pc_ctrl         = {stall, flush};
    redirect_pc     = redir;
    imem_req_ready  = ready;
    imem_resp_valid = rv;
    imem_resp_data  = rv ? mem_data : $urandom;
    #1;
    req_v = model_req();
    pres  = (m_out && !m_disc && rv) || m_held;
    ev    = pres && !flush;
    esr   = !m_boot && !pres;
    ei    = ev ? (m_held ? m_hdata : mem_data) : NOP_INSTR;
    ereq  = {esr, 5'b00000};
    acc   = req_v && ready;

    total++;
    if (imem_req_valid !== req_v) begin
      bad++; $display("FAIL %s req_valid: got %b want %b", cur_test, imem_req_valid, req_v);
    end
    if (req_v) begin
      total++;
      if (imem_req_addr !== m_pc) begin
        bad++; $display("FAIL %s req_addr: got %h want %h", cur_test, imem_req_addr, m_pc);
      end
    end
    total++;
    if (if_valid !== ev) begin
      bad++; $display("FAIL %s if_valid: got %b want %b", cur_test, if_valid, ev);
    end
    total++;
    if (if_instr !== ei) begin
      bad++; $display("FAIL %s if_instr: got %h want %h", cur_test, if_instr, ei);
    end
    if (ev) begin
      total++;
      if (if_pc !== m_pc) begin
        bad++; $display("FAIL %s if_pc: got %h want %h", cur_test, if_pc, m_pc);
      end
    end
    total++;
    if (if_req !== ereq) begin
      bad++; $display("FAIL %s if_req: got %b want %b", cur_test, if_req, ereq);
    end
`ifdef RV5STAGE_FETCH_PERF_EN
    total++;
    if (perf_fetched !== m_fetched || perf_stall_cycles !== m_stalls) begin
      bad++;
      $display("FAIL %s perf: got %0d/%0d want %0d/%0d", cur_test,
               perf_fetched, perf_stall_cycles, m_fetched, m_stalls);
    end
`endif
    if (ev && !stall) $display("deliver pc=%h instr=%h", m_pc, ei);
    if (acc) acc_q.push_back(imem_req_addr);

    if (ev && !stall && m_fetched != 32'hFFFF_FFFF) m_fetched++;
    if (esr && m_stalls != 32'hFFFF_FFFF) m_stalls++;

    // Advance the reference model.
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (flush) begin
      m_pc   = redir;
      m_held = 1'b0;
      if (m_out && rv) begin
        m_out = 1'b0; m_disc = 1'b0;
      end else if (m_out) begin
        m_disc = 1'b1;
      end
      if (acc) begin
        m_out = 1'b1; m_disc = 1'b1;
      end
    end else begin
      if (m_out && rv) begin
        m_out = 1'b0;
        if (!m_disc) begin
          if (stall) begin
            m_held = 1'b1; m_hdata = mem_data;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
        m_disc = 1'b0;
      end else if (m_held && !stall) begin
        m_held = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
      if (acc) begin
        m_out = 1'b1; m_disc = 1'b0;
      end
    end

    // Advance the memory model.
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = lat - 1;
      mem_data = force_data ? forced_val : $urandom;
      force_data = 1'b0;
    end
    @(posedge clk);
  endtask

  // Run idle cycles until the model expects a request to be presented.
  task automatic goto_req();
    int n = 0;
    while (!model_req() && n < 20) begin
      step(1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    if (!model_req()) begin
      total++; bad++;
      $display("FAIL %s goto_req: no request within 20 cycles", cur_test);
    end
  endtask

  task automatic check_reset_outputs(input string what);
    total++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP_INSTR ||
        if_pc !== RESET_PC || if_req !== 6'b0 || imem_req_addr !== RESET_PC) begin
      bad++;
      $display("FAIL %s: got req_v=%b v=%b instr=%h pc=%h req=%b addr=%h want 0 0 %h %h 0 %h",
               what, imem_req_valid, if_valid, if_instr, if_pc, if_req, imem_req_addr,
               NOP_INSTR, RESET_PC, RESET_PC);
    end
`ifdef RV5STAGE_FETCH_PERF_EN
    total++;
    if (perf_fetched !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL %s perf: got %0d/%0d want 0/0", what, perf_fetched, perf_stall_cycles);
    end
`endif
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    cur_test = "sequential";
    lat = 1;
    acc_q.delete();
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);
    total++;
    if (acc_q.size() < 3) begin
      bad++; $display("FAIL seq_count: got %0d accepts want >=3", acc_q.size());
    end else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
      bad++;
      $display("FAIL seq_addrs: got %h %h %h want 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] p0;
    cur_test = "stall_hold";
    goto_req();
    lat = 1; force_data = 1'b1; forced_val = 32'h0050_0093;
    p0 = m_pc;
    step(1'b0, 1'b0, '0, 1'b1);           // accept
    repeat (3) step(1'b1, 1'b0, '0, 1'b1); // response arrives and is held
    step(1'b0, 1'b0, '0, 1'b1);            // stall falls, delivered
    #2;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== p0 + 32'd4) begin
      bad++;
      $display("FAIL stall_advance: got v=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, p0 + 32'd4);
    end
  endtask

  task automatic test_flush_wait();
    cur_test = "flush_wait";
    goto_req();
    lat = 2;
    step(1'b0, 1'b0, '0, 1'b1);                // accept
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);     // flush before response
    step(1'b0, 1'b0, '0, 1'b1);                // stale response drained
    #2;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin
      bad++;
      $display("FAIL flush_wait_addr: got v=%b addr=%h want 1 00000100", imem_req_valid, imem_req_addr);
    end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_flush_resp();
    cur_test = "flush_resp";
    goto_req();
    lat = 1;
    step(1'b0, 1'b0, '0, 1'b1);                // accept
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);     // flush with response
    #2;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0200) begin
      bad++;
      $display("FAIL flush_resp_addr: got v=%b addr=%h want 1 00000200", imem_req_valid, imem_req_addr);
    end
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);     // requesting, not draining
  endtask

  task automatic test_hold_flush();
    cur_test = "hold_flush";
    goto_req();
    lat = 1;
    step(1'b0, 1'b0, '0, 1'b1);                // accept
    step(1'b1, 1'b0, '0, 1'b1);                // response while stalled
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);     // flush and stall in HOLD
    #2;
    total++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0300) begin
      bad++;
      $display("FAIL hold_flush: got v=%b req=%b addr=%h want 0 1 00000300",
               if_valid, imem_req_valid, imem_req_addr);
    end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_ready_low();
    cur_test = "ready_low";
    goto_req();
    repeat (5) step(1'b0, 1'b0, '0, 1'b0);
    lat = 1;
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    cur_test = "random";
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 3));
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
           {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom_range(0, 9) < 7);
    end
  endtask

  task automatic test_reset_midwait();
    cur_test = "reset_midwait";
    goto_req();
    lat = 3;
    step(1'b0, 1'b0, '0, 1'b1);   // accept, now waiting
    @(negedge clk);
    rst_n = 1'b0;
    pc_ctrl = 2'b00;
    imem_resp_valid = 1'b0;
    #1;
    check_reset_outputs("reset_midwait");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    lat = 1;
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall_hold();
    test_flush_wait();
    test_flush_resp();
    test_hold_flush();
    test_ready_low();
    test_random();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
